reservatorio_rolhas_param: RTL and testbench
============================================

Name: reservatorio_rolhas_param

Overview:
Parametrised next-generation cork magazine controller for the bottle-sealing station. It tracks corks in the dispenser (contagem) and in the reserve (estoque). Automatic refill is a sequenced one-cork-per-cycle transfer FSM, not a single-cycle jump. Adds a consume request/acknowledge handshake, reserve restocking, a low-stock alarm and a refill-complete pulse.

Parameters:
CW, 6, width of contagem
EW, 8, width of estoque
MAX_ROLHAS, 31, dispenser capacity (must be < 2^CW)
VALOR_INICIAL, 6, contagem after reset
ESTOQUE_INICIAL, 60, estoque after reset
CONTAGEM_MINIMA, 5, refill trigger threshold (contagem <= this)
RECARGA_AUTO, 15, maximum corks moved per refill burst
LOTE_REPOSICAO, 30, corks added to estoque per repor pulse
ESTOQUE_ALERTA, 10, estoque_baixo asserted when estoque <= this

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
dec  input  1  consume request (one cork per cycle while high)
add_manual  input  1  move one cork estoque->dispenser (OCIOSO only)
repor  input  1  reserve restock pulse
contagem  output  CW  corks in dispenser (registered)
estoque  output  EW  corks in reserve (registered)
dec_ack  output  1  registered pulse: previous-cycle dec accepted
rolha_disponivel  output  1  contagem > 0 (combinational)
disp_acionado  output  1  high while FSM in RECARGA
recarga_concluida  output  1  one-cycle pulse in FIM
estoque_baixo  output  1  estoque <= ESTOQUE_ALERTA (combinational)

Behaviour:
- Reset (async, any state, mid-burst included): contagem=VALOR_INICIAL, estoque=ESTOQUE_INICIAL, FSM=OCIOSO, burst counter=0, dec_ack=0, recarga_concluida=0.
- FSM states: OCIOSO, RECARGA, FIM.
- OCIOSO -> RECARGA when contagem <= CONTAGEM_MINIMA and estoque > 0. Evaluate on registered values; the transition cycle moves no cork.
- RECARGA: each cycle move one cork: contagem+1, estoque-1, burst counter+1.
- RECARGA -> FIM when the move just made reaches any of: burst = RECARGA_AUTO, estoque = 0, contagem = MAX_ROLHAS. If estoque = 0 or contagem = MAX_ROLHAS on entry to a cycle, no move that cycle; go straight to FIM.
- FIM: recarga_concluida=1 for one cycle. Burst counter cleared. Return to OCIOSO, which re-evaluates the trigger on the next cycle.
- dec accepted in any state when contagem > 0: contagem-1 and dec_ack=1 in the next cycle. With dec=1 and contagem=0: no change, dec_ack=0.
- dec and a RECARGA move in the same cycle: contagem net unchanged; estoque-1 and burst+1 still apply.
- add_manual: only in OCIOSO with dec=0, contagem < MAX_ROLHAS, estoque > 0 and refill trigger false. Moves one cork. Ignored otherwise.
- Priority in OCIOSO: refill trigger > dec > add_manual.
- repor: estoque += LOTE_REPOSICAO in any state. Combined with a same-cycle decrement as estoque - moved + LOTE_REPOSICAO. Saturates at 2^EW-1.
- No wrap-around: contagem never exceeds MAX_ROLHAS and never goes below 0; estoque never goes below 0.

Optional Feature:
CONSUMO_TOTAL_EN: when defined, adds output total_consumido [15:0]. It is reset to 0, increments on every accepted dec and wraps at 65535->0. When undefined, the port and its counter are absent and all other behaviour is identical.

Test Plan:
- Reset, idle: contagem=6 > 5, so no refill. Pulse dec once -> contagem=5 next cycle, dec_ack=1. FSM enters RECARGA and moves 15 corks over 15 cycles -> contagem=20, estoque=45, then one recarga_concluida pulse.
- Refill limited by reserve: estoque=3, contagem=2 -> 3 moves, contagem=5, estoque=0, FIM, return to OCIOSO. No re-entry since estoque=0; estoque_baixo=1.
- Refill limited by capacity: contagem=5 with MAX_ROLHAS=12 -> 7 moves, contagem=12, then FIM.
- dec held high through a whole burst (contagem=5, estoque=45) -> contagem stays 5 each move cycle; estoque falls 1 per cycle; burst ends after 15 moves.
- dec held with contagem=0, estoque=0 -> dec_ack stays 0, contagem stays 0. Then repor -> estoque=30 and refill starts. repor at estoque=250 with EW=8 -> estoque=255.
- Assert reset during RECARGA after 4 moves -> outputs at reset values immediately; FSM=OCIOSO.

Source files
------------

// File: rtl/reservatorio_rolhas_param.sv
// -----------------------------------------------------------------------------
// reservatorio_rolhas_param
//
// Cork magazine controller for the bottle-sealing station. It tracks the corks
// held in the dispenser (contagem) and in the reserve (estoque). When the
// dispenser runs low, a refill FSM moves corks from the reserve into the
// dispenser, one cork per cycle. Each refill burst stops at RECARGA_AUTO
// corks, when the reserve empties, or when the dispenser is full.
//
// Ports:
//   clk                in   system clock, rising edge
//   reset              in   asynchronous, active-high reset
//   dec                in   consume request, one cork per cycle while high
//   add_manual         in   move one cork from reserve to dispenser (idle only)
//   repor              in   restock pulse, adds LOTE_REPOSICAO to the reserve
//   contagem           out  corks in the dispenser (registered)
//   estoque            out  corks in the reserve (registered)
//   dec_ack            out  registered pulse: the previous-cycle dec was taken
//   rolha_disponivel   out  contagem > 0
//   disp_acionado      out  high while a refill burst is running
//   recarga_concluida  out  one-cycle pulse when a refill burst ends
//   estoque_baixo      out  estoque <= ESTOQUE_ALERTA
//   total_consumido    out  16-bit wrapping count of accepted dec requests
//                           (present only when CONSUMO_TOTAL_EN is defined)
//
// Optional feature macro: CONSUMO_TOTAL_EN
// -----------------------------------------------------------------------------
module reservatorio_rolhas_param #(
    parameter int CW              = 6,
    parameter int EW              = 8,
    parameter int MAX_ROLHAS      = 31,
    parameter int VALOR_INICIAL   = 6,
    parameter int ESTOQUE_INICIAL = 60,
    parameter int CONTAGEM_MINIMA = 5,
    parameter int RECARGA_AUTO    = 15,
    parameter int LOTE_REPOSICAO  = 30,
    parameter int ESTOQUE_ALERTA  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          add_manual,
    input  logic          repor,
    output logic [CW-1:0] contagem,
    output logic [EW-1:0] estoque,
    output logic          dec_ack,
    output logic          rolha_disponivel,
    output logic          disp_acionado,
    output logic          recarga_concluida,
    output logic          estoque_baixo
`ifdef CONSUMO_TOTAL_EN
    ,
    output logic [15:0]   total_consumido
`endif
);

    // Burst counter must be able to hold RECARGA_AUTO itself.
    localparam int BW = $clog2(RECARGA_AUTO + 1);

    localparam logic [CW-1:0] MAX_C     = CW'(MAX_ROLHAS);
    localparam logic [CW-1:0] MINIMA_C  = CW'(CONTAGEM_MINIMA);
    localparam logic [CW-1:0] INICIAL_C = CW'(VALOR_INICIAL);
    localparam logic [EW-1:0] INICIAL_E = EW'(ESTOQUE_INICIAL);
    localparam logic [EW-1:0] ALERTA_E  = EW'(ESTOQUE_ALERTA);
    localparam logic [EW:0]   LOTE_W    = (EW + 1)'(LOTE_REPOSICAO);
    localparam logic [BW-1:0] AUTO_B    = BW'(RECARGA_AUTO);

    typedef enum logic [1:0] {
        OCIOSO,
        RECARGA,
        FIM
    } estado_t;

    estado_t       estado, estado_prox;
    logic [BW-1:0] burst, burst_prox;
    logic [CW-1:0] contagem_prox;
    logic [EW-1:0] estoque_prox;
    logic [EW:0]   estoque_soma;
    logic          gatilho;
    logic          aceita_dec;
    logic          move;

    // Refill trigger and dec acceptance both look at registered values only.
    assign gatilho    = (contagem <= MINIMA_C) && (estoque != '0);
    assign aceita_dec = dec && (contagem != '0);

    // -------------------------------------------------------------------------
    // Next-state and datapath decisions
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can
        // leave it unassigned and infer a latch.
        estado_prox = estado;
        burst_prox  = burst;
        move        = 1'b0;

        unique case (estado)
            OCIOSO: begin
                // The transition cycle itself moves no cork; add_manual only
                // wins when neither the trigger nor dec claims the cycle.
                if (gatilho) begin
                    estado_prox = RECARGA;
                end else if (add_manual && !dec && (contagem < MAX_C) &&
                             (estoque != '0)) begin
                    move = 1'b1;
                end
            end

            RECARGA: begin
                if ((estoque == '0) || (contagem == MAX_C)) begin
                    // Nothing left to move or no room: close the burst now.
                    estado_prox = FIM;
                end else begin
                    move       = 1'b1;
                    burst_prox = burst + BW'(1);
                    // Stop when the move just made hits any of the limits.
                    // A same-cycle dec cancels the dispenser gain.
                    if ((burst_prox == AUTO_B) || (estoque == EW'(1)) ||
                        ((contagem + CW'(1) - CW'(aceita_dec)) == MAX_C)) begin
                        estado_prox = FIM;
                    end
                end
            end

            FIM: begin
                estado_prox = OCIOSO;
                burst_prox  = '0;
            end

            default: begin
                estado_prox = OCIOSO;
                burst_prox  = '0;
            end
        endcase

        // A move only happens below MAX_ROLHAS and dec only above 0, so this
        // never wraps in either direction.
        contagem_prox = contagem + CW'(move) - CW'(aceita_dec);

        // One extra bit catches restock overflow; a move only happens with
        // estoque > 0, so the subtraction cannot underflow.
        estoque_soma = {1'b0, estoque} - (EW + 1)'(move) +
                       (repor ? LOTE_W : '0);
        estoque_prox = estoque_soma[EW] ? '1 : estoque_soma[EW-1:0];
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            burst    <= '0;
            contagem <= INICIAL_C;
            estoque  <= INICIAL_E;
            dec_ack  <= 1'b0;
        end else begin
            estado   <= estado_prox;
            burst    <= burst_prox;
            contagem <= contagem_prox;
            estoque  <= estoque_prox;
            dec_ack  <= aceita_dec;
        end
    end

`ifdef CONSUMO_TOTAL_EN
    // Wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_consumido <= '0;
        end else if (aceita_dec) begin
            total_consumido <= total_consumido + 16'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign rolha_disponivel  = (contagem != '0);
    assign disp_acionado     = (estado == RECARGA);
    assign recarga_concluida = (estado == FIM);
    assign estoque_baixo     = (estoque <= ALERTA_E);

endmodule

// File: tb/tb_reservatorio_rolhas_param.sv
// -----------------------------------------------------------------------------
// tb_reservatorio_rolhas_param
//
// Self-checking bench for reservatorio_rolhas_param with default parameters.
// A cycle-level reference model built from cork counts (plain integers)
// predicts every output after each clock edge. Directed sequences cover the
// refill burst, manual fill to capacity, reset mid-burst, draining to empty,
// restock and saturation. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_reservatorio_rolhas_param;

    localparam int CW              = 6;
    localparam int EW              = 8;
    localparam int MAX_ROLHAS      = 31;
    localparam int VALOR_INICIAL   = 6;
    localparam int ESTOQUE_INICIAL = 60;
    localparam int CONTAGEM_MINIMA = 5;
    localparam int RECARGA_AUTO    = 15;
    localparam int LOTE_REPOSICAO  = 30;
    localparam int ESTOQUE_ALERTA  = 10;
    localparam int ESTOQUE_TETO    = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dec = 1'b0;
    logic          add_manual = 1'b0;
    logic          repor = 1'b0;
    logic [CW-1:0] contagem;
    logic [EW-1:0] estoque;
    logic          dec_ack;
    logic          rolha_disponivel;
    logic          disp_acionado;
    logic          recarga_concluida;
    logic          estoque_baixo;
`ifdef CONSUMO_TOTAL_EN
    logic [15:0]   total_consumido;
`endif

    always #5 clk = ~clk;

    reservatorio_rolhas_param #(
        .CW              (CW),
        .EW              (EW),
        .MAX_ROLHAS      (MAX_ROLHAS),
        .VALOR_INICIAL   (VALOR_INICIAL),
        .ESTOQUE_INICIAL (ESTOQUE_INICIAL),
        .CONTAGEM_MINIMA (CONTAGEM_MINIMA),
        .RECARGA_AUTO    (RECARGA_AUTO),
        .LOTE_REPOSICAO  (LOTE_REPOSICAO),
        .ESTOQUE_ALERTA  (ESTOQUE_ALERTA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .dec               (dec),
        .add_manual        (add_manual),
        .repor             (repor),
        .contagem          (contagem),
        .estoque           (estoque),
        .dec_ack           (dec_ack),
        .rolha_disponivel  (rolha_disponivel),
        .disp_acionado     (disp_acionado),
        .recarga_concluida (recarga_concluida),
        .estoque_baixo     (estoque_baixo)
`ifdef CONSUMO_TOTAL_EN
        ,
        .total_consumido   (total_consumido)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed,
                     expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: cork counts plus the refill burst progress.
    //   m_refill  : a burst is under way
    //   m_closing : the burst just ended, concluding pulse this cycle
    // ------------------------------------------------------------------
    int m_cont, m_est, m_moved_in_burst, m_total;
    bit m_refill, m_closing, m_ack;

    task automatic model_reset();
        m_cont          = VALOR_INICIAL;
        m_est           = ESTOQUE_INICIAL;
        m_moved_in_burst = 0;
        m_total         = 0;
        m_refill        = 0;
        m_closing       = 0;
        m_ack           = 0;
    endtask

    task automatic model_step(input bit d, input bit a, input bit r);
        bit taken;
        int moved;
        bit start_refill, end_refill, leave_closing;
        taken         = d && (m_cont > 0);
        moved         = 0;
        start_refill  = 0;
        end_refill    = 0;
        leave_closing = 0;
        if (m_closing) begin
            leave_closing    = 1;
            m_moved_in_burst = 0;
        end else if (m_refill) begin
            if (m_est == 0 || m_cont == MAX_ROLHAS) begin
                end_refill = 1;
            end else begin
                moved = 1;
                m_moved_in_burst++;
                if (m_moved_in_burst == RECARGA_AUTO || m_est - 1 == 0 ||
                    m_cont + 1 - int'(taken) == MAX_ROLHAS)
                    end_refill = 1;
            end
        end else begin
            if (m_cont <= CONTAGEM_MINIMA && m_est > 0)
                start_refill = 1;
            else if (a && !d && m_cont < MAX_ROLHAS && m_est > 0)
                moved = 1;
        end
        m_cont = m_cont + moved - int'(taken);
        m_est  = m_est - moved + (r ? LOTE_REPOSICAO : 0);
        if (m_est > ESTOQUE_TETO) m_est = ESTOQUE_TETO;
        m_ack = taken;
        if (taken) m_total = (m_total + 1) % 65536;
        if (start_refill) m_refill = 1;
        if (end_refill) begin
            m_refill  = 0;
            m_closing = 1;
        end
        if (leave_closing) m_closing = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".contagem"}, 32'(contagem), m_cont);
        check({tag, ".estoque"}, 32'(estoque), m_est);
        check({tag, ".dec_ack"}, 32'(dec_ack), 32'(m_ack));
        check({tag, ".rolha_disponivel"}, 32'(rolha_disponivel), 32'(m_cont > 0));
        check({tag, ".disp_acionado"}, 32'(disp_acionado), 32'(m_refill));
        check({tag, ".recarga_concluida"}, 32'(recarga_concluida), 32'(m_closing));
        check({tag, ".estoque_baixo"}, 32'(estoque_baixo),
              32'(m_est <= ESTOQUE_ALERTA));
`ifdef CONSUMO_TOTAL_EN
        check({tag, ".total_consumido"}, 32'(total_consumido), m_total);
`endif
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge.
    task automatic step(input bit d, input bit a, input bit r, input string tag);
        @(negedge clk);
        dec        = d;
        add_manual = a;
        repor      = r;
        @(posedge clk);
        model_step(d, a, r);
        #1;
        compare_all(tag);
    endtask

    // Reset is raised mid-cycle and checked before any clock edge arrives,
    // which shows it acts asynchronously.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        dec        = 0;
        add_manual = 0;
        repor      = 0;
        reset      = 1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_reset();

        // Reset and the first automatic burst.
        pulse_reset("reset");
        check("reset.contagem_6", 32'(contagem), 6);
        check("reset.estoque_60", 32'(estoque), 60);

        step(1, 0, 0, "dec_once");
        check("dec_once.contagem_5", 32'(contagem), 5);
        check("dec_once.ack", 32'(dec_ack), 1);

        repeat (16) step(0, 0, 0, "burst");
        check("burst.contagem_20", 32'(contagem), 20);
        check("burst.estoque_45", 32'(estoque), 45);
        check("burst.concluida", 32'(recarga_concluida), 1);
        step(0, 0, 0, "burst_end");
        check("burst_end.idle", 32'(disp_acionado), 0);

        // Manual fill up to capacity; extra requests are ignored.
        repeat (13) step(0, 1, 0, "manual");
        check("manual.contagem_max", 32'(contagem), MAX_ROLHAS);
        check("manual.estoque_34", 32'(estoque), 34);

        // Reset in the middle of a burst, after four moves.
        pulse_reset("reset2");
        step(1, 0, 0, "pre_burst");
        repeat (5) step(0, 0, 0, "mid_burst");
        check("mid_burst.contagem_9", 32'(contagem), 9);
        check("mid_burst.refilling", 32'(disp_acionado), 1);
        pulse_reset("reset_mid");
        check("reset_mid.contagem_6", 32'(contagem), 6);
        check("reset_mid.estoque_60", 32'(estoque), 60);
        check("reset_mid.idle", 32'(disp_acionado), 0);

        // Drain everything with dec held; bursts end on an empty reserve.
        repeat (300) step(1, 0, 0, "drain");
        check("drain.contagem_0", 32'(contagem), 0);
        check("drain.estoque_0", 32'(estoque), 0);
        check("drain.ack_0", 32'(dec_ack), 0);
        check("drain.baixo", 32'(estoque_baixo), 1);

        // Restock, then watch the refill kick in.
        step(1, 0, 1, "restock");
        check("restock.estoque_30", 32'(estoque), 30);
        repeat (3) step(1, 0, 0, "restock_refill");
        check("restock_refill.active", 32'(disp_acionado), 1);

        // Repeated restocks saturate the reserve.
        repeat (10) step(0, 0, 1, "saturate");
        check("saturate.estoque_255", 32'(estoque), ESTOQUE_TETO);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset("rand_reset");
            end else begin
                step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 30,
                     $urandom_range(0, 99) < 4, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
